// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage of the 24-bit pipeline.
// Optional feature: MEM_TIMEOUT_EN (abort a data-memory access after TIMEOUT wait cycles).
package mem_stage_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 24;
    localparam int unsigned ADDR_W_DEFAULT  = 10;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } mem_state_t;

    // Control bits carried from M into W.
    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } mw_ctrl_t;

    function automatic logic is_mem_op(input logic memtoreg, input logic memwrite);
        return memtoreg | memwrite;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack port between the memory stage (master) and data memory (slave).
interface memory_stage_if #(
    parameter int unsigned N      = 24,
    parameter int unsigned ADDR_W = 10
) ();

    logic              DMemReq;
    logic              DMemWe;
    logic [ADDR_W-1:0] DMemAddr;
    logic [N-1:0]      DMemWData;
    logic              DMemAck;
    logic [N-1:0]      DMemRData;

    modport master (
        output DMemReq,
        output DMemWe,
        output DMemAddr,
        output DMemWData,
        input  DMemAck,
        input  DMemRData
    );

    modport slave (
        input  DMemReq,
        input  DMemWe,
        input  DMemAddr,
        input  DMemWData,
        output DMemAck,
        output DMemRData
    );

endinterface

// File: rtl/register_MW.sv
// M/W pipeline register. Loads every cycle; a bubble clears the control bits and the error flag
// so a stalled instruction never writes back early.
module register_MW
    import mem_stage_pkg::*;
#(
    parameter int unsigned N = DATA_W_DEFAULT
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     bubble_i,
    input  mw_ctrl_t ctrl_i,
    input  logic [N-1:0] read_data_i,
    input  logic [N-1:0] alu_out_i,
    input  logic [3:0]   wa3_i,
    input  logic         mem_err_i,
    output mw_ctrl_t     ctrl_o,
    output logic [N-1:0] read_data_o,
    output logic [N-1:0] alu_out_o,
    output logic [3:0]   wa3_o,
    output logic         mem_err_o
);

    mw_ctrl_t     ctrl_q;
    logic [N-1:0] read_data_q;
    logic [N-1:0] alu_out_q;
    logic [3:0]   wa3_q;
    logic         mem_err_q;

    // Pipeline register with bubble insertion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q      <= '0;
            read_data_q <= '0;
            alu_out_q   <= '0;
            wa3_q       <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            ctrl_q      <= bubble_i ? '0 : ctrl_i;
            read_data_q <= bubble_i ? '0 : read_data_i;
            alu_out_q   <= alu_out_i;
            wa3_q       <= wa3_i;
            mem_err_q   <= bubble_i ? 1'b0 : mem_err_i;
        end
    end

    assign ctrl_o      = ctrl_q;
    assign read_data_o = read_data_q;
    assign alu_out_o   = alu_out_q;
    assign wa3_o       = wa3_q;
    assign mem_err_o   = mem_err_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: runs loads/stores over a req/ack data-memory port, stalls upstream while an
// access is pending and feeds the M/W register. Optional MEM_TIMEOUT_EN aborts an access that
// has waited TIMEOUT cycles without ack and flags it through MemErrW.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned N       = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PCSrcM,
    input  logic         RegWriteM,
    input  logic         MemtoRegM,
    input  logic         MemWriteM,
    input  logic [N-1:0] ALUResultM,
    input  logic [N-1:0] WriteDataM,
    input  logic [3:0]   WA3M,
    output logic [N-1:0] ALUResultMFB,
    output logic         StallM,
    memory_stage_if.master dmem,
    output logic         PCSrcW,
    output logic         RegWriteW,
    output logic         MemtoRegW,
    output logic [N-1:0] ReadDataW,
    output logic [N-1:0] ALUOutW,
    output logic [3:0]   WA3W,
    output logic         MemErrW
);

    mem_state_t state_q, state_d;

    // Request latches: hold the access stable while waiting for ack.
    logic [ADDR_W-1:0] addr_q;
    logic [N-1:0]      wdata_q;
    logic              we_q;
    logic [N-1:0]      alu_q;
    logic [3:0]        wa3_q;
    mw_ctrl_t          ctrl_q;
    logic              latch_en;

    logic              mem_op;
    logic              req;
    logic              timeout_hit;

    // M/W register inputs.
    logic              mw_bubble;
    mw_ctrl_t          mw_ctrl;
    mw_ctrl_t          ctrl_w;
    logic [N-1:0]      mw_rdata;
    logic [N-1:0]      mw_alu;
    logic [3:0]        mw_wa3;
    logic              mw_err;

    assign mem_op       = is_mem_op(MemtoRegM, MemWriteM);
    assign ALUResultMFB = ALUResultM;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    // Wait-cycle counter; cleared whenever the FSM is not waiting or the access completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == WAIT && !dmem.DMemAck && !timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (cnt_q == CntW'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches, captured when a new access has to wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            alu_q   <= '0;
            wa3_q   <= '0;
            ctrl_q  <= '0;
        end else if (latch_en) begin
            addr_q  <= ALUResultM[ADDR_W-1:0];
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
            alu_q   <= ALUResultM;
            wa3_q   <= WA3M;
            ctrl_q  <= '{pcsrc: PCSrcM, regwrite: RegWriteM, memtoreg: MemtoRegM};
        end
    end

    // Next state, memory port drive and M/W register inputs.
    always_comb begin
        state_d        = state_q;
        req            = 1'b0;
        latch_en       = 1'b0;
        dmem.DMemWe    = MemWriteM;
        dmem.DMemAddr  = ALUResultM[ADDR_W-1:0];
        dmem.DMemWData = WriteDataM;
        mw_bubble      = 1'b0;
        mw_ctrl        = '{pcsrc: PCSrcM, regwrite: RegWriteM, memtoreg: MemtoRegM};
        mw_rdata       = '0;
        mw_alu         = ALUResultM;
        mw_wa3         = WA3M;
        mw_err         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (dmem.DMemAck) begin
                        mw_rdata = MemtoRegM ? dmem.DMemRData : '0;
                    end else begin
                        latch_en  = 1'b1;
                        mw_bubble = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                req            = 1'b1;
                dmem.DMemWe    = we_q;
                dmem.DMemAddr  = addr_q;
                dmem.DMemWData = wdata_q;
                mw_ctrl        = ctrl_q;
                mw_alu         = alu_q;
                mw_wa3         = wa3_q;
                if (dmem.DMemAck) begin
                    // An ack on the timeout cycle still completes normally.
                    mw_rdata = ctrl_q.memtoreg ? dmem.DMemRData : '0;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    req     = 1'b0;
                    mw_ctrl = '0;
                    mw_err  = 1'b1;
                    state_d = IDLE;
                end else begin
                    mw_bubble = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops the request immediately, even before the state register clears.
    assign dmem.DMemReq = req & rst;
    assign StallM       = dmem.DMemReq & ~dmem.DMemAck;

    register_MW #(
        .N (N)
    ) u_register_mw (
        .clk_i       (clk),
        .rst_ni      (rst),
        .bubble_i    (mw_bubble),
        .ctrl_i      (mw_ctrl),
        .read_data_i (mw_rdata),
        .alu_out_i   (mw_alu),
        .wa3_i       (mw_wa3),
        .mem_err_i   (mw_err),
        .ctrl_o      (ctrl_w),
        .read_data_o (ReadDataW),
        .alu_out_o   (ALUOutW),
        .wa3_o       (WA3W),
        .mem_err_o   (MemErrW)
    );

    assign PCSrcW    = ctrl_w.pcsrc;
    assign RegWriteW = ctrl_w.regwrite;
    assign MemtoRegW = ctrl_w.memtoreg;

endmodule
